loop_filter_pi: RTL and testbench
=================================

// Module: loop_filter_pi
// PURPOSE
//   Parametrised 2nd-order (proportional + integral) loop filter for carrier/timing recovery loops.
//   Takes the phase-detector error, integrates it with gain 2^-C2, adds proportional gain 2^-C1,
//   and issues one frequency-control word to the NCO every UPDATE_DIV clocks.
//   Adds runtime gain shifts, integrator saturation (anti-windup), hold, sync clear and a valid strobe.
// PARAMETERS
//   DW          27  pd input width, signed
//   OW          27  frequency_df output width, signed
//   AW          32  integrator width, signed; AW >= DW, AW >= OW
//   UPDATE_DIV  8   clocks per update; legal 2..256
//   SW          5   width of runtime shift inputs
// PORTS
//   clk           in   1     system clock; all logic on rising edge
//   rst           in   1     asynchronous reset, active-low (rst==0 resets)
//   en            in   1     1: phase counter advances; 0: all state frozen
//   clr           in   1     synchronous clear of counter, integrator, output
//   hold          in   1     1: integrator frozen, proportional path still active
//   c1_shift      in   SW    proportional gain exponent, gain = 2^-c1_shift
//   c2_shift      in   SW    integral gain exponent, gain = 2^-c2_shift
//   pd            in   DW    signed phase-detector error
//   frequency_df  out  OW    signed loop-filter output / NCO frequency word
//   df_valid      out  1     one-clock strobe, high in the cycle frequency_df takes a new value
//   int_sat       out  1     sticky: integrator hit a rail since last clr/reset
// BEHAVIOUR
//   Reset (rst==0, asynchronous): cnt=0, sum=0, pd_s=0, frequency_df=0, df_valid=0, int_sat=0.
//   Phase counter cnt: 0..UPDATE_DIV-1, wraps to 0; advances only when en=1 and clr=0.
//   Priority each clock: rst > clr > en. clr=1: cnt=0, sum=0, frequency_df=0, df_valid=0, int_sat=0.
//   en=0: cnt, sum, pd_s, frequency_df, int_sat hold; df_valid=0.
//   cnt==0 (en=1): pd_s <= pd;
//     if hold=0: sum <= SAT_AW(sum + (sext(pd) >>> c2_shift)); if hold=1: sum unchanged.
//   cnt==1 (en=1): frequency_df <= SAT_OW(sum + (sext(pd_s) >>> c1_shift)); df_valid <= 1.
//     Uses sum already updated at cnt==0 and pd_s sampled at cnt==0 (not live pd).
//   df_valid is 0 in every other cycle; exactly one strobe per UPDATE_DIV enabled clocks.
//   Arithmetic: >>> is arithmetic shift (floor toward -inf). Sums computed at AW+1 bits, no wrap.
//   SAT_AW clamps to [-2^(AW-1), 2^(AW-1)-1]; SAT_OW clamps to [-2^(OW-1), 2^(OW-1)-1].
//   Shift >= AW yields 0 for non-negative, -1 for negative operand.
//   int_sat sets when SAT_AW clamps; cleared only by clr or reset.
//   Shift inputs sampled in the cycle they are used; changes mid-period take effect at next use.
//   Latency: pd sampled at cnt==0 appears in frequency_df 2 clocks later with df_valid.
//   clr or rst mid-period: next update sequence restarts from cnt==0.
// TESTING
//   T1 reset: rst=0 with pd=1000 -> frequency_df=0, df_valid=0, int_sat=0; rst release, en=0 -> no df_valid.
//   T2 step: defaults, c1=6, c2=13, pd=+2^20 constant, en=1 -> first df_valid 2 clks after cnt==0:
//      frequency_df=128+16384=16512; each later strobe (every 8 clks) +128.
//   T3 negative floor: pd=-1, c1=6, c2=13 -> integrator -1 per update, frequency_df=-1+(-1)... i.e. sum-1; after 1st update -2.
//   T4 windup: AW=32, c2=0, pd=max positive held -> sum clamps at 2^31-1, int_sat=1,
//      frequency_df pinned at 2^26-1; then pd negative -> sum decreases immediately (no wrap).
//   T5 hold/clr: hold=1 for 3 periods -> sum constant, frequency_df tracks pd_s>>>c1 only;
//      clr pulse at cnt==5 -> all zero next clk, next strobe exactly 2 clks after clr release.
//   T6 en gating + UPDATE_DIV=2: toggle en every other clk -> strobe count = enabled clks/2, values match model.

Source files
------------

// File: rtl/loop_filter_pi.sv
// Second-order PI loop filter: integrates the phase error with gain 2^-c2, adds a 2^-c1
// proportional term and issues one saturated frequency word every UPDATE_DIV enabled clocks.
module loop_filter_pi #(
    parameter int unsigned DW         = 27,
    parameter int unsigned OW         = 27,
    parameter int unsigned AW         = 32,
    parameter int unsigned UPDATE_DIV = 8,
    parameter int unsigned SW         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 hold,
    input  logic [SW-1:0]        c1_shift,
    input  logic [SW-1:0]        c2_shift,
    input  logic signed [DW-1:0] pd,
    output logic signed [OW-1:0] frequency_df,
    output logic                 df_valid,
    output logic                 int_sat
);

    localparam int unsigned CW = $clog2(UPDATE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(UPDATE_DIV - 1);
    localparam logic [CW-1:0] CNT_OUT  = CW'(1);

    localparam logic signed [AW-1:0] AW_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AW_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [OW-1:0] OW_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OW_MIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [AW:0]   OW_MAX_X = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0]   OW_MIN_X = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic [CW-1:0]        cnt, cnt_nxt;
    logic signed [AW-1:0] sum, sum_nxt;
    logic signed [DW-1:0] pd_s, pd_s_nxt;
    logic signed [OW-1:0] df_nxt;
    logic                 valid_nxt;
    logic                 sat_nxt;

    // Datapath runs one bit wider than the integrator so no sum can wrap before clamping.
    logic signed [AW:0]   pd_x, pd_s_x;
    logic signed [AW:0]   int_term, prop_term;
    logic signed [AW:0]   acc_raw, out_raw;
    logic                 acc_clamp;
    logic signed [AW-1:0] acc_sat;
    logic                 out_hi, out_lo;
    logic signed [OW-1:0] out_sat;

    assign pd_x      = (AW+1)'(pd);
    assign pd_s_x    = (AW+1)'(pd_s);
    assign int_term  = pd_x >>> c2_shift;
    assign prop_term = pd_s_x >>> c1_shift;
    assign acc_raw   = (AW+1)'(sum) + int_term;
    assign out_raw   = (AW+1)'(sum) + prop_term;

    // Integrator rail clamp: top two bits disagree only when the AW-bit range is exceeded.
    assign acc_clamp = acc_raw[AW] != acc_raw[AW-1];
    assign acc_sat   = acc_clamp ? (acc_raw[AW] ? AW_MIN : AW_MAX) : acc_raw[AW-1:0];

    assign out_hi  = out_raw > OW_MAX_X;
    assign out_lo  = out_raw < OW_MIN_X;
    assign out_sat = out_hi ? OW_MAX : (out_lo ? OW_MIN : out_raw[OW-1:0]);

    // Next-state: clr beats en; integrate at phase 0, publish at phase 1.
    always_comb begin
        cnt_nxt   = cnt;
        sum_nxt   = sum;
        pd_s_nxt  = pd_s;
        df_nxt    = frequency_df;
        valid_nxt = 1'b0;
        sat_nxt   = int_sat;
        if (clr) begin
            cnt_nxt = '0;
            sum_nxt = '0;
            df_nxt  = '0;
            sat_nxt = 1'b0;
        end else if (en) begin
            cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (cnt == '0) begin
                pd_s_nxt = pd;
                if (!hold) begin
                    sum_nxt = acc_sat;
                    if (acc_clamp) begin
                        sat_nxt = 1'b1;
                    end
                end
            end
            if (cnt == CNT_OUT) begin
                df_nxt    = out_sat;
                valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            sum          <= '0;
            pd_s         <= '0;
            frequency_df <= '0;
            df_valid     <= 1'b0;
            int_sat      <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            sum          <= sum_nxt;
            pd_s         <= pd_s_nxt;
            frequency_df <= df_nxt;
            df_valid     <= valid_nxt;
            int_sat      <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_loop_filter_pi.sv
// Bench for loop_filter_pi: directed vector table, hand sequences for windup/hold/clr/gating,
// and random stimulus against an integer-arithmetic model for UPDATE_DIV=8 and UPDATE_DIV=2.
`timescale 1ns/1ps
module tb_loop_filter_pi;

    localparam int DW = 27;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 clr;
    logic                 hold;
    logic [4:0]           c1;
    logic [4:0]           c2;
    logic signed [DW-1:0] pd;
    logic signed [26:0]   df_a, df_b;
    logic                 v_a, v_b, s_a, s_b;

    int total = 0;
    int bad   = 0;

    loop_filter_pi dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .hold(hold),
        .c1_shift(c1), .c2_shift(c2), .pd(pd),
        .frequency_df(df_a), .df_valid(v_a), .int_sat(s_a)
    );

    loop_filter_pi #(.UPDATE_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .hold(hold),
        .c1_shift(c1), .c2_shift(c2), .pd(pd),
        .frequency_df(df_b), .df_valid(v_b), .int_sat(s_b)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, floor division by powers of two.
    longint m_sum[2], m_pds[2], m_df[2];
    int     m_cnt[2];
    bit     m_val[2], m_sat[2];
    int     divs[2] = '{8, 2};

    localparam longint A_MAX = (64'sd1 <<< 31) - 1;
    localparam longint A_MIN = -(64'sd1 <<< 31);
    localparam longint O_MAX = (64'sd1 <<< 26) - 1;
    localparam longint O_MIN = -(64'sd1 <<< 26);

    function automatic longint fdiv(input longint x, input int s);
        longint d, q;
        d = 64'sd1 <<< s;
        q = x / d;
        if (x < 0 && (x % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0; m_pds[i] = 0; m_df[i] = 0;
            m_cnt[i] = 0; m_val[i] = 0; m_sat[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        longint t;
        m_val[i] = 0;
        if (clr) begin
            m_cnt[i] = 0; m_sum[i] = 0; m_df[i] = 0; m_sat[i] = 0;
        end else if (en) begin
            if (m_cnt[i] == 0) begin
                m_pds[i] = longint'(pd);
                if (!hold) begin
                    t = m_sum[i] + fdiv(longint'(pd), int'(c2));
                    if (t > A_MAX) begin t = A_MAX; m_sat[i] = 1; end
                    if (t < A_MIN) begin t = A_MIN; m_sat[i] = 1; end
                    m_sum[i] = t;
                end
            end else if (m_cnt[i] == 1) begin
                t = m_sum[i] + fdiv(m_pds[i], int'(c1));
                if (t > O_MAX) t = O_MAX;
                if (t < O_MIN) t = O_MIN;
                m_df[i]  = t;
                m_val[i] = 1;
            end
            m_cnt[i] = (m_cnt[i] + 1) % divs[i];
        end
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_df_a", df_a, m_df[0]);
        chk("model_valid_a", v_a, m_val[0]);
        chk("model_sat_a", s_a, m_sat[0]);
        chk("model_df_b", df_b, m_df[1]);
        chk("model_valid_b", v_b, m_val[1]);
        chk("model_sat_b", s_b, m_sat[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    typedef struct {
        bit     en, clr, hold;
        int     c1, c2;
        longint pd;
        longint exp_df;
        bit     exp_v, exp_s;
    } vec_t;

    function automatic vec_t mk(input bit e, input bit c, input int s1, input int s2,
                                input longint p, input longint df, input bit v);
        vec_t r;
        r.en = e; r.clr = c; r.hold = 1'b0; r.c1 = s1; r.c2 = s2; r.pd = p;
        r.exp_df = df; r.exp_v = v; r.exp_s = 1'b0;
        return r;
    endfunction

    vec_t tbl[21];

    initial begin
        int na, nb;

        // Step response (pd=2^20, c1=6, c2=13), then negative floor behaviour (pd=-1).
        tbl[0] = mk(1, 0, 6, 13, 64'sd1 <<< 20, 0, 0);
        tbl[1] = mk(1, 0, 6, 13, 64'sd1 <<< 20, 16512, 1);
        for (int r = 2; r <= 8; r++) tbl[r] = mk(1, 0, 6, 13, 64'sd1 <<< 20, 16512, 0);
        tbl[9]  = mk(1, 0, 6, 13, 64'sd1 <<< 20, 16640, 1);
        tbl[10] = mk(1, 1, 6, 13, -1, 0, 0);
        tbl[11] = mk(1, 0, 6, 13, -1, 0, 0);
        tbl[12] = mk(1, 0, 6, 13, -1, -2, 1);
        for (int r = 13; r <= 19; r++) tbl[r] = mk(1, 0, 6, 13, -1, -2, 0);
        tbl[20] = mk(1, 0, 6, 13, -1, -3, 1);

        // Reset with activity on the inputs.
        rst = 1'b0; en = 1'b1; clr = 1'b0; hold = 1'b0; c1 = 5'd6; c2 = 5'd13; pd = DW'(1000);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_df", df_a, 0);
        chk("reset_valid", v_a, 0);
        chk("reset_sat", s_a, 0);
        rst = 1'b1; en = 1'b0;
        repeat (6) cycle();

        for (int r = 0; r < 21; r++) begin
            en = tbl[r].en; clr = tbl[r].clr; hold = tbl[r].hold;
            c1 = 5'(tbl[r].c1); c2 = 5'(tbl[r].c2); pd = DW'(tbl[r].pd);
            cycle();
            chk($sformatf("tbl%0d_df", r), df_a, tbl[r].exp_df);
            chk($sformatf("tbl%0d_valid", r), v_a, tbl[r].exp_v);
            chk($sformatf("tbl%0d_sat", r), s_a, tbl[r].exp_s);
        end

        // Windup: max positive error with unity integral gain pins the integrator, then unwinds.
        en = 1'b1; hold = 1'b0;
        do_clr();
        c1 = 5'd0; c2 = 5'd0; pd = DW'(O_MAX);
        repeat (40 * 8) cycle();
        chk("windup_sat", s_a, 1);
        chk("windup_df", df_a, O_MAX);
        pd = DW'(O_MIN);
        repeat (31 * 8) cycle();
        chk("unwind_df", df_a, -1);
        chk("unwind_sat_sticky", s_a, 1);

        // Hold: integrator frozen at 124, output follows pd_s>>>2 only.
        do_clr();
        c1 = 5'd2; c2 = 5'd4; pd = DW'(1000);
        repeat (16) cycle();
        chk("prehold_df", df_a, 374);
        hold = 1'b1; pd = DW'(400);
        repeat (8) cycle();
        chk("hold1_df", df_a, 224);
        pd = DW'(-401);
        repeat (8) cycle();
        chk("hold2_df", df_a, 23);
        pd = DW'(7);
        repeat (8) cycle();
        chk("hold3_df", df_a, 125);

        // Clear mid-period at cnt==5; the next strobe lands two clocks after release.
        hold = 1'b0; pd = DW'(1000);
        repeat (5) cycle();
        clr = 1'b1;
        cycle();
        chk("clr_df", df_a, 0);
        chk("clr_valid", v_a, 0);
        clr = 1'b0;
        cycle();
        chk("post_clr1_valid", v_a, 0);
        cycle();
        chk("post_clr2_valid", v_a, 1);
        chk("post_clr2_df", df_a, 312);

        // en toggling: 32 enabled clocks out of 64.
        en = 1'b1; c1 = 5'd3; c2 = 5'd5; pd = DW'(-5000);
        do_clr();
        na = 0; nb = 0;
        for (int i = 0; i < 64; i++) begin
            en = (i % 2 == 0);
            cycle();
            if (v_a) na++;
            if (v_b) nb++;
        end
        chk("gated_strobes_div8", na, 4);
        chk("gated_strobes_div2", nb, 16);

        // Randomized traffic checked cycle by cycle against the model.
        for (int k = 0; k < 1500; k++) begin
            en   = ($urandom_range(0, 7) != 0);
            clr  = ($urandom_range(0, 199) == 0);
            hold = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                c1 = 5'($urandom);
                c2 = 5'($urandom);
            end
            case ($urandom_range(0, 4))
                0:       pd = DW'($urandom);
                1:       pd = DW'(O_MAX);
                2:       pd = DW'(O_MIN);
                default: pd = DW'(longint'($urandom_range(0, 4000)) - 2000);
            endcase
            cycle();
        end

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_df", df_a, 0);
        chk("async_rst_sat", s_a, 0);
        chk("async_rst_valid", v_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
